// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [1:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [1:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_Src_A,
  output logic [WIDTH-1:0] alu_Src_B,
  output logic [1:0]       alu_ALUControl,
  input  logic [WIDTH-1:0] alu_ALUResult,
  input  logic [3:0]       alu_ALUFlags
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic             owner;
  logic             grant;
  logic             accept;
  logic             owner_rsp_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_ctrl;

  // Grant selection: the pointer only matters when both requesters contend.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ptr;
    end else begin
      grant = req1_valid;
    end
  end

  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        accept     = req0_valid || req1_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        if (accept) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (owner_rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture on acceptance; the pointer moves past whoever was just served.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ptr     <= PRIO_INIT;
      owner   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_ctrl <= 2'b00;
    end else if (accept) begin
      ptr     <= ~grant;
      owner   <= grant;
      op_a    <= grant ? req1_A : req0_A;
      op_b    <= grant ? req1_B : req0_B;
      op_ctrl <= grant ? req1_ctrl : req0_ctrl;
    end
  end

  // Result capture at the end of the single ISSUE cycle; held through RESP.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      rsp_result <= '0;
      rsp_flags  <= 4'b0000;
    end else if (state == ST_ISSUE) begin
      rsp_result <= alu_ALUResult;
      rsp_flags  <= alu_ALUFlags;
    end
  end

  assign alu_Src_A      = op_a;
  assign alu_Src_B      = op_b;
  assign alu_ALUControl = op_ctrl;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESETn;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
  logic [1:0]   req0_ctrl, req1_ctrl;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [W-1:0] alu_Src_A, alu_Src_B, alu_ALUResult;
  logic [1:0]   alu_ALUControl;
  logic [3:0]   alu_ALUFlags;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  alu_share_arbiter #(.WIDTH(W), .PRIO_INIT(1'b0)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_Src_A(alu_Src_A), .alu_Src_B(alu_Src_B), .alu_ALUControl(alu_ALUControl),
    .alu_ALUResult(alu_ALUResult), .alu_ALUFlags(alu_ALUFlags)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference ALU: returns {result, N, Z, C, V}. SUB carry means no borrow.
  function automatic logic [W+3:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] c);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         cf, vf;
    cf = 1'b0;
    vf = 1'b0;
    case (c)
      2'b00: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[W-1:0]; cf = wide[W];
        vf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b01: begin
        wide = {1'b0, a} + {1'b0, ~b} + 1;
        r = wide[W-1:0]; cf = wide[W];
        vf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r, r[W-1], (r == '0), cf, vf};
  endfunction

  // The external ALU the arbiter drives.
  always_comb {alu_ALUResult, alu_ALUFlags} = alu_f(alu_Src_A, alu_Src_B, alu_ALUControl);

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Timeline model: an accepted op owns the unit from acceptance cycle t,
  // responds from t+2 until consumed, then the unit is free the following cycle.
  bit           m_ok = 0;
  bit           m_busy, m_ptr, m_own;
  int           m_acc;
  logic [W-1:0] m_a, m_b, m_res;
  logic [1:0]   m_c;
  logic [3:0]   m_flg;

  // Per-cycle comparison against the model, then advance the model over the coming edge.
  always @(negedge CLK) begin
    bit e_r0, e_r1, e_rv;
    e_r0 = !m_busy && req0_valid && (!req1_valid || !m_ptr);
    e_r1 = !m_busy && req1_valid && (!req0_valid || m_ptr);
    e_rv = m_busy && (cyc >= m_acc + 2);
    if (m_ok) begin
      chk("cmp_req0_ready", req0_ready, e_r0);
      chk("cmp_req1_ready", req1_ready, e_r1);
      chk("cmp_rsp0_valid", rsp0_valid, e_rv && !m_own);
      chk("cmp_rsp1_valid", rsp1_valid, e_rv && m_own);
      chk("cmp_rsp_result", rsp_result, m_res);
      chk("cmp_rsp_flags", rsp_flags, m_flg);
      chk("cmp_alu_Src_A", alu_Src_A, m_a);
      chk("cmp_alu_Src_B", alu_Src_B, m_b);
      chk("cmp_alu_ctrl", alu_ALUControl, m_c);
    end
    if (!RESETn) begin
      m_ok = 1; m_busy = 0; m_ptr = 0; m_own = 0; m_acc = 0;
      m_a = '0; m_b = '0; m_c = 2'b00; m_res = '0; m_flg = 4'b0000;
    end else if (m_ok) begin
      if (e_r0 || e_r1) begin
        m_busy = 1; m_acc = cyc; m_own = e_r1; m_ptr = !e_r1;
        m_a = e_r1 ? req1_A : req0_A;
        m_b = e_r1 ? req1_B : req0_B;
        m_c = e_r1 ? req1_ctrl : req0_ctrl;
      end else if (m_busy && cyc == m_acc + 1) begin
        {m_res, m_flg} = alu_f(m_a, m_b, m_c);
      end else if (e_rv && (m_own ? rsp1_ready : rsp0_ready)) begin
        m_busy = 0;
      end
    end
  end

  task automatic drive(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] c);
    if (n == 0) begin
      req0_valid = 1; req0_A = a; req0_B = b; req0_ctrl = c;
    end else begin
      req1_valid = 1; req1_A = a; req1_B = b; req1_ctrl = c;
    end
  endtask

  // Waits (bounded) for the requester's ready, then drops its valid after the accepting edge.
  task automatic wait_accept(input int n, output int acc);
    bit got = 0;
    acc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if ((n == 0) ? req0_ready : req1_ready) begin
        got = 1; acc = cyc;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge CLK); #1;
    if (n == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic send(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] c, output int acc);
    @(posedge CLK); #1;
    drive(n, a, b, c);
    wait_accept(n, acc);
  endtask

  task automatic wait_rsp(input int n, output int rc);
    bit got = 0;
    rc = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if ((n == 0) ? rsp0_valid : rsp1_valid) begin
        got = 1; rc = cyc;
      end
    end
    if (!got) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ta, tr, seen, ng;
    int g_id[4];
    int g_cy[4];
    RESETn = 0; req0_valid = 0; req1_valid = 0;
    req0_A = '0; req0_B = '0; req0_ctrl = 2'b00;
    req1_A = '0; req1_B = '0; req1_ctrl = 2'b00;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) @(posedge CLK);
    #1;

    // Reset state.
    @(negedge CLK);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_alu_Src_A", alu_Src_A, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);

    // Contention from the first cycle after reset: strict alternation, 3 cycles apart.
    @(posedge CLK); #1;
    RESETn = 1;
    drive(0, 32'd1, 32'd2, 2'b00);
    drive(1, 32'd9, 32'd4, 2'b01);
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge CLK);
      if (req0_ready || req1_ready) begin
        g_id[ng] = req1_ready ? 1 : 0; g_cy[ng] = cyc; ng++;
      end
    end
    @(posedge CLK); #1;
    req0_valid = 0; req1_valid = 0;
    chk("t3_grant_count", ng, 4);
    chk("t3_order0", g_id[0], 0);
    chk("t3_order1", g_id[1], 1);
    chk("t3_order2", g_id[2], 0);
    chk("t3_order3", g_id[3], 1);
    chk("t3_gap01", g_cy[1] - g_cy[0], 3);
    chk("t3_gap12", g_cy[2] - g_cy[1], 3);
    chk("t3_gap23", g_cy[3] - g_cy[2], 3);
    wait_rsp(1, tr);
    chk("t3_last_result", rsp_result, 32'd5);

    // ADD 5+3: no carry out, so all flags clear.
    send(0, 32'd5, 32'd3, 2'b00, ta);
    wait_rsp(0, tr);
    chk("t1_latency", tr - ta, 2);
    chk("t1_result", rsp_result, 32'd8);
    chk("t1_flags", rsp_flags, 4'b0000);

    // SUB 3-3: zero with no borrow.
    send(1, 32'd3, 32'd3, 2'b01, ta);
    wait_rsp(1, tr);
    chk("t2_result", rsp_result, 32'd0);
    chk("t2_flags", rsp_flags, 4'b0110);
    chk("t2_rsp0_quiet", rsp0_valid, 0);

    // Signed overflow with the consumer stalled; a competing request must wait.
    rsp0_ready = 0;
    send(0, 32'h7FFF_FFFF, 32'd1, 2'b00, ta);
    wait_rsp(0, tr);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      if (k == 0) drive(1, 32'd10, 32'd4, 2'b01);
      @(negedge CLK);
      chk("t4_rsp0_valid", rsp0_valid, 1);
      chk("t4_result", rsp_result, 32'h8000_0000);
      chk("t4_flags", rsp_flags, 4'b1001);
      chk("t4_req0_ready", req0_ready, 0);
      chk("t4_req1_ready", req1_ready, 0);
    end
    @(posedge CLK); #1;
    rsp0_ready = 1;
    wait_accept(1, ta);
    wait_rsp(1, tr);
    chk("t4_req1_result", rsp_result, 32'd6);
    chk("t4_req1_flags", rsp_flags, 4'b0010);

    // Reset during ISSUE discards the operation.
    send(0, 32'd7, 32'd9, 2'b00, ta);
    RESETn = 0;
    @(posedge CLK); #1;
    RESETn = 1;
    @(negedge CLK);
    chk("t5_rsp0_valid", rsp0_valid, 0);
    chk("t5_alu_Src_A", alu_Src_A, 0);
    chk("t5_alu_Src_B", alu_Src_B, 0);
    chk("t5_alu_ctrl", alu_ALUControl, 0);
    chk("t5_rsp_result", rsp_result, 0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (rsp0_valid || rsp1_valid) seen++;
    end
    chk("t5_no_rsp", seen, 0);

    // Logic operations clear C and V.
    send(0, 32'h0000_F0F0, 32'h0000_FF00, 2'b10, ta);
    wait_rsp(0, tr);
    chk("t6_and_result", rsp_result, 32'h0000_F000);
    chk("t6_and_flags", rsp_flags, 4'b0000);
    send(0, 32'h0000_F0F0, 32'h0000_0F0F, 2'b11, ta);
    wait_rsp(0, tr);
    chk("t6_orr_result", rsp_result, 32'h0000_FFFF);
    chk("t6_orr_flags", rsp_flags, 4'b0000);

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
